// File: rtl/triangle_wireframe_drawer_pkg.sv
// Shared types for the wireframe back end: screen vertex layout, visible area, drawer states.
package render_pkg;
  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
  } scr_vertex_t;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} wf_state_t;
endpackage

// File: rtl/triangle_wireframe_drawer_bresenham_stepper.sv
// Walks one Bresenham edge from start (inclusive) towards end (exclusive).
// load captures the edge; each step moves one point; last flags the step that lands on the end vertex.
module bresenham_stepper #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  output logic [9:0] cur_x,
  output logic [9:0] cur_y,
  output logic       at_end,
  output logic       last,
  output logic       on_screen
);
  logic [9:0]        x, y, xe, ye, x_nxt, y_nxt;
  logic signed [11:0] dx, dy, err, err_nxt, dx_ld, dy_ld;
  logic signed [12:0] e2, dx_w, dy_w;
  logic              sx_neg, sy_neg, mx, my;

  always_comb begin
    dx_ld   = (x1 >= x0) ? $signed({2'b00, x1 - x0}) : $signed({2'b00, x0 - x1});
    dy_ld   = (y1 >= y0) ? -$signed({2'b00, y1 - y0}) : -$signed({2'b00, y0 - y1});
    e2      = {err, 1'b0};
    dx_w    = {dx[11], dx};
    dy_w    = {dy[11], dy};
    mx      = (e2 >= dy_w);
    my      = (e2 <= dx_w);
    // Both axis updates may apply in the same step (diagonal move).
    err_nxt = err + (mx ? dy : 12'sd0) + (my ? dx : 12'sd0);
    x_nxt   = mx ? (sx_neg ? x - 10'd1 : x + 10'd1) : x;
    y_nxt   = my ? (sy_neg ? y - 10'd1 : y + 10'd1) : y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      xe     <= '0;
      ye     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      x      <= x0;
      y      <= y0;
      xe     <= x1;
      ye     <= y1;
      dx     <= dx_ld;
      dy     <= dy_ld;
      err    <= dx_ld + dy_ld;
      sx_neg <= (x1 < x0);
      sy_neg <= (y1 < y0);
    end else if (step) begin
      x   <= x_nxt;
      y   <= y_nxt;
      err <= err_nxt;
    end
  end

  assign cur_x     = x;
  assign cur_y     = y;
  assign at_end    = (x == xe) && (y == ye);
  assign last      = (x_nxt == xe) && (y_nxt == ye);
  assign on_screen = (int'(x) < H_RES) && (int'(y) < V_RES);
endmodule

// File: rtl/triangle_wireframe_drawer.sv
// Rasterises the three edges of one accepted triangle into a pixel-write stream.
// Holds the sequencing FSM, edge counter, latched vertices and colour; the stepper does the arithmetic.
module triangle_wireframe_drawer
  import render_pkg::*;
#(
  parameter int CW    = 8,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  tri_valid,
  output logic                  tri_ready,
  input  logic [2:0][1:0][9:0]  proj_triangle,
  input  logic                  clip,
  input  logic [CW-1:0]         color,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [9:0]            px_x,
  output logic [9:0]            px_y,
  output logic [CW-1:0]         px_color,
  output logic                  busy,
  output logic                  done
);
  wf_state_t         state, state_nxt;
  logic [1:0]        edge_idx, edge_nxt;
  scr_vertex_t [2:0] verts;
  logic [CW-1:0]     color_q;
  scr_vertex_t       v_start, v_end;
  logic              accept, load, step, at_end, last, on_screen, zero_len, last_edge;

  // Edge order V1->V2, V2->V3, V3->V1; verts[2] is V1.
  always_comb begin
    v_start = verts[0];
    v_end   = verts[2];
    case (edge_idx)
      2'd0:    begin v_start = verts[2]; v_end = verts[1]; end
      2'd1:    begin v_start = verts[1]; v_end = verts[0]; end
      default: begin v_start = verts[0]; v_end = verts[2]; end
    endcase
  end

  assign accept    = tri_valid & tri_ready;
  assign zero_len  = (v_start == v_end);
  assign last_edge = (edge_idx == 2'd2);
  assign load      = (state == SETUP);
  assign step      = (state == DRAW) && !at_end && (!on_screen || px_ready);

  bresenham_stepper #(.H_RES(H_RES), .V_RES(V_RES)) u_stepper (
    .clk       (Clk),
    .rst       (Reset),
    .load      (load),
    .step      (step),
    .x0        (v_start.x),
    .y0        (v_start.y),
    .x1        (v_end.x),
    .y1        (v_end.y),
    .cur_x     (px_x),
    .cur_y     (px_y),
    .at_end    (at_end),
    .last      (last),
    .on_screen (on_screen)
  );

  always_comb begin
    state_nxt = state;
    edge_nxt  = edge_idx;
    case (state)
      IDLE: if (accept) begin
        edge_nxt  = 2'd0;
        state_nxt = clip ? DONE : SETUP;
      end
      SETUP: begin
        // Zero-length edges emit nothing and skip straight to the next edge.
        if (zero_len) begin
          if (last_edge) state_nxt = DONE;
          else edge_nxt = edge_idx + 2'd1;
        end else begin
          state_nxt = DRAW;
        end
      end
      DRAW: if (at_end || (step && last)) begin
        if (last_edge) state_nxt = DONE;
        else begin
          state_nxt = SETUP;
          edge_nxt  = edge_idx + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      edge_idx <= '0;
      verts    <= '0;
      color_q  <= '0;
    end else begin
      state    <= state_nxt;
      edge_idx <= edge_nxt;
      if (accept) begin
        verts   <= proj_triangle;
        color_q <= color;
      end
    end
  end

  assign tri_ready = (state == IDLE) && !Reset;
  assign px_valid  = (state == DRAW) && !at_end && on_screen;
  assign px_color  = color_q;
  assign busy      = (state == SETUP) || (state == DRAW);
  assign done      = (state == DONE);
endmodule
